div_seq: RTL and testbench
==========================

// Module: div_seq
// PURPOSE
//  Multi-cycle sequencer for the HI/LO divide path of the open_mips core: runs DIV/DIVU
//  as a 32-iteration restoring division and returns {HI=remainder, LO=quotient}.
//  Sits beside the EX stage. EX holds start/operands and stalls the pipeline through
//  stall_req until ready. The 64-bit result is written to HI/LO through the existing
//  hilo write path (the same path MTHI/MTLO use).
// PARAMETERS
//  WIDTH   32   operand width; result is 2*WIDTH, iteration count = WIDTH
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        synchronous, active-high reset
//  start        in   1        EX requests divide; held high until ready seen
//  annul        in   1        cancel current divide (flush/exception)
//  signed_div   in   1        1=DIV (two's complement), 0=DIVU
//  opdata1      in   WIDTH    dividend (rs)
//  opdata2      in   WIDTH    divisor (rt)
//  result       out  2*WIDTH  {remainder, quotient} -> {HI, LO}
//  ready        out  1        result valid
//  stall_req    out  1        combinational: start & ~ready
// BEHAVIOUR
//  - Reset: state=FREE, cnt=0, result=0, ready=0, internal dividend reg=0.
//  - Reset is synchronous and wins over every other input in any state, mid-divide included.
//  - States: FREE, BY_ZERO, ON, END (2-bit encoding).
//  - FREE:
//      - if start & ~annul & opdata2==0 -> BY_ZERO.
//      - if start & ~annul & opdata2!=0 -> ON: latch |opdata1| and |opdata2|
//        (abs only when signed_div), plus both operand signs; cnt=0.
//      - else stay; result=0, ready=0.
//  - ON: annul=1 -> FREE (ready stays 0, result 0). Otherwise one restoring step per cycle:
//      - trial = rem_hi - divisor (WIDTH+1 bits).
//      - if trial is negative: shift left, inserting 0.
//      - else: rem_hi=trial, shift left, inserting 1.
//      - cnt++.
//      - when cnt==WIDTH: apply sign fix and go to END.
//          - quotient negated if signed_div & (sign1^sign2).
//          - remainder negated if signed_div & sign1.
//  - BY_ZERO: next cycle -> END with result=0.
//  - END: result valid, ready=1. When start drops -> FREE with ready=0 and result=0.
//      - While start stays high, END holds: no new divide starts.
//  - Latency: start sampled at edge E0.
//      - Iterations occur on E1..E32.
//      - ready is high after E33 (zero divisor: after E1).
//      - EX stalls 33 cycles.
//  - annul in END or BY_ZERO -> FREE.
//  - annul together with start in FREE -> no accept.
//  - Most-negative / -1 (0x80000000 / 0xFFFFFFFF signed): result is the wrapped value
//    LO=0x80000000, HI=0. No trap is raised.
//  - opdata1/opdata2/signed_div are ignored after acceptance; only latched values are used.
// STRUCTURE
//  - Shared defines (include file): state encodings DivFree/DivByZero/DivOn/DivEnd,
//    DivResultReady/NotReady, DivStart/Stop, ZeroWord.
//  - One sub-module: div_step, combinational single iteration.
//      - in: rem/dividend shift reg [2*WIDTH:0] and divisor.
//      - out: next shift reg.
//  - FSM, counter, sign fix and handshake stay in div_seq.
// TESTING
//  - DIVU 7/2, start held -> ready after 33 cycles; result = HI 0x00000001, LO 0x00000003;
//    stall_req high for exactly 33 cycles.
//  - DIV -7/2 (0xFFFFFFF9, 0x00000002) -> LO 0xFFFFFFFD, HI 0xFFFFFFFF.
//    DIV 7/-2 -> LO 0xFFFFFFFD, HI 0x00000001.
//  - DIVU 0xFFFFFFFF/0 -> ready after 1 cycle, result 0.
//    DIVU 0xFFFFFFFF/1 -> LO 0xFFFFFFFF, HI 0.
//  - annul at iteration 10 -> FREE next cycle, ready never asserts.
//    A following DIVU 0x05050000/0x00010000 -> LO 0x00000505, HI 0.
//  - start held 5 cycles after ready -> result stable; drop start -> ready=0, result=0
//    next cycle. Back-to-back start immediately accepted from FREE.
//  - rst=1 asserted mid-ON -> next edge state FREE, ready 0, result 0.
//    After rst=0, a fresh DIVU 100/7 -> LO 14, HI 2.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared encodings for the HI/LO divide sequencer.
package div_seq_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   // Handshake levels
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

   // Architectural zero word
   localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on the combined remainder/dividend shift register.
// Layout: shift_in[2W:W] is the partial remainder with the next dividend bit appended,
// shift_in[W-1:0] collects quotient bits from the right.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH:0] shift_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [2*WIDTH:0] shift_out
);

   logic [WIDTH:0] trial_s;
   logic           neg_s;

   // Trial subtraction and restore/keep decision for one quotient bit
   always_comb begin
      trial_s = {1'b0, shift_in[2*WIDTH-1:WIDTH]} - {1'b0, divisor};
      // A set top bit means the partial remainder already exceeds any divisor
      neg_s   = trial_s[WIDTH] & ~shift_in[2*WIDTH];
      if (neg_s) begin
         shift_out = {shift_in[2*WIDTH-1:0], 1'b0};
      end else begin
         shift_out = {trial_s[WIDTH-1:0], shift_in[WIDTH-1:0], 1'b1};
      end
   end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer returning {HI=remainder, LO=quotient}.
// Operands are latched as magnitudes at acceptance; signs are reapplied at the end.
module div_seq
   import div_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               annul,
   input  logic               signed_div,
   input  logic [WIDTH-1:0]   opdata1,
   input  logic [WIDTH-1:0]   opdata2,
   output logic [2*WIDTH-1:0] result,
   output logic               ready,
   output logic               stall_req
);

   localparam int                CNT_W    = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   div_state_e           state_r,   state_s;
   logic [CNT_W-1:0]     cnt_r,     cnt_s;
   logic [2*WIDTH:0]     shift_r,   shift_s;
   logic [WIDTH-1:0]     divisor_r, divisor_s;
   logic                 sign1_r,   sign1_s;
   logic                 sign2_r,   sign2_s;
   logic                 sdiv_r,    sdiv_s;
   logic [2*WIDTH-1:0]   result_r,  result_s;
   logic                 ready_r,   ready_s;

   logic [2*WIDTH:0]     step_s;
   logic [WIDTH-1:0]     abs1_s, abs2_s;
   logic [WIDTH-1:0]     quot_fix_s, rem_fix_s;

   div_step #(.WIDTH(WIDTH)) u_step (
      .shift_in  (shift_r),
      .divisor   (divisor_r),
      .shift_out (step_s)
   );

   // Operand magnitudes for the signed case (most-negative maps onto itself as unsigned)
   always_comb begin
      if (signed_div && opdata1[WIDTH-1]) begin
         abs1_s = {WIDTH{1'b0}} - opdata1;
      end else begin
         abs1_s = opdata1;
      end
      if (signed_div && opdata2[WIDTH-1]) begin
         abs2_s = {WIDTH{1'b0}} - opdata2;
      end else begin
         abs2_s = opdata2;
      end
   end

   // Sign restoration: quotient follows sign1^sign2, remainder follows the dividend
   always_comb begin
      if (sdiv_r && (sign1_r ^ sign2_r)) begin
         quot_fix_s = {WIDTH{1'b0}} - shift_r[WIDTH-1:0];
      end else begin
         quot_fix_s = shift_r[WIDTH-1:0];
      end
      if (sdiv_r && sign1_r) begin
         rem_fix_s = {WIDTH{1'b0}} - shift_r[2*WIDTH:WIDTH+1];
      end else begin
         rem_fix_s = shift_r[2*WIDTH:WIDTH+1];
      end
   end

   // Next-state, datapath and handshake decisions
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      shift_s   = shift_r;
      divisor_s = divisor_r;
      sign1_s   = sign1_r;
      sign2_s   = sign2_r;
      sdiv_s    = sdiv_r;
      result_s  = result_r;
      ready_s   = ready_r;
      case (state_r)
         DivFree: begin
            result_s = {(2*WIDTH){1'b0}};
            ready_s  = DivResultNotReady;
            if ((start == DivStart) && !annul) begin
               if (opdata2 == {WIDTH{1'b0}}) begin
                  state_s = DivByZero;
               end else begin
                  state_s   = DivOn;
                  shift_s   = {{WIDTH{1'b0}}, abs1_s, 1'b0};
                  divisor_s = abs2_s;
                  sign1_s   = opdata1[WIDTH-1];
                  sign2_s   = opdata2[WIDTH-1];
                  sdiv_s    = signed_div;
                  cnt_s     = {CNT_W{1'b0}};
               end
            end else begin
               state_s = DivFree;
            end
         end
         DivByZero: begin
            if (annul) begin
               state_s  = DivFree;
               result_s = {(2*WIDTH){1'b0}};
               ready_s  = DivResultNotReady;
            end else begin
               state_s  = DivEnd;
               result_s = {(2*WIDTH){1'b0}};
               ready_s  = DivResultReady;
            end
         end
         DivOn: begin
            if (annul) begin
               state_s  = DivFree;
               result_s = {(2*WIDTH){1'b0}};
               ready_s  = DivResultNotReady;
            end else if (cnt_r == CNT_LAST) begin
               state_s  = DivEnd;
               result_s = {rem_fix_s, quot_fix_s};
               ready_s  = DivResultReady;
            end else begin
               shift_s = step_s;
               cnt_s   = cnt_r + CNT_ONE;
            end
         end
         DivEnd: begin
            if (annul || (start == DivStop)) begin
               state_s  = DivFree;
               result_s = {(2*WIDTH){1'b0}};
               ready_s  = DivResultNotReady;
            end else begin
               state_s = DivEnd;
            end
         end
         default: begin
            state_s  = DivFree;
            result_s = {(2*WIDTH){1'b0}};
            ready_s  = DivResultNotReady;
         end
      endcase
   end

   // State and datapath registers; synchronous reset overrides everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= DivFree;
         cnt_r     <= {CNT_W{1'b0}};
         shift_r   <= {(2*WIDTH+1){1'b0}};
         divisor_r <= {WIDTH{1'b0}};
         sign1_r   <= 1'b0;
         sign2_r   <= 1'b0;
         sdiv_r    <= 1'b0;
         result_r  <= {(2*WIDTH){1'b0}};
         ready_r   <= DivResultNotReady;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         shift_r   <= shift_s;
         divisor_r <= divisor_s;
         sign1_r   <= sign1_s;
         sign2_r   <= sign2_s;
         sdiv_r    <= sdiv_s;
         result_r  <= result_s;
         ready_r   <= ready_s;
      end
   end

   assign result    = result_r;
   assign ready     = ready_r;
   assign stall_req = start & ~ready_r;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: transaction-level reference model plus directed
// literal cases and randomized divides.
module tb_div_seq;

   logic        clk = 1'b0;
   logic        rst, start, annul, signed_div;
   logic [31:0] opdata1, opdata2;
   logic [63:0] result;
   logic        ready, stall_req;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // Reference model state
   int          m_phase = 0;   // 0 idle, 1 busy, 2 result held
   int          m_left  = 0;
   logic [63:0] m_pend  = 64'h0;
   logic        exp_ready  = 1'b0;
   logic [63:0] exp_result = 64'h0;

   div_seq #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .annul      (annul),
      .signed_div (signed_div),
      .opdata1    (opdata1),
      .opdata2    (opdata2),
      .result     (result),
      .ready      (ready),
      .stall_req  (stall_req)
   );

   always #5 clk = ~clk;

   // Plain arithmetic reference: 64-bit division so most-negative / -1 wraps cleanly
   function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'h0) return 64'h0;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'h0, a});
         sb = longint'({32'h0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: accept, count down the fixed latency, hold until start drops
   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0; exp_ready = 1'b0; exp_result = 64'h0;
      end else if (m_phase == 0) begin
         exp_ready = 1'b0; exp_result = 64'h0;
         if (start && !annul) begin
            m_pend  = ref_div(signed_div, opdata1, opdata2);
            m_left  = (opdata2 == 32'h0) ? 1 : 33;
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (annul) begin
            m_phase = 0;
         end else begin
            m_left--;
            if (m_left == 0) begin
               m_phase = 2; exp_ready = 1'b1; exp_result = m_pend;
            end
         end
      end else begin
         if (annul || !start) begin
            m_phase = 0; exp_ready = 1'b0; exp_result = 64'h0;
         end
      end
   end

   // Cycle compare against the model, after the edge has settled
   always @(posedge clk) begin
      #2;
      if (chk_en) begin
         chk("cyc_ready", {63'h0, ready}, {63'h0, exp_ready});
         chk("cyc_result", result, exp_result);
         chk("cyc_stall", {63'h0, stall_req}, {63'h0, start & ~exp_ready});
      end
   end

   // One complete divide: latency, stall length, held result, release
   task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int exp_lat, input int hold, input string name);
      int n, stalls;
      @(negedge clk);
      start = 1'b1; annul = 1'b0; signed_div = s; opdata1 = a; opdata2 = b;
      n = 0; stalls = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            opdata1 = $urandom; opdata2 = $urandom; signed_div = 1'($urandom);
         end
         if (!ready && stall_req) stalls++;
      end while (!ready && n < 100);
      chk({name, "_lat"}, 64'(n - 1), 64'(exp_lat));
      chk({name, "_stall"}, 64'(stalls), 64'(exp_lat));
      chk({name, "_res"}, result, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({name, "_hold"}, {63'h0, ready}, 64'h1);
         chk({name, "_hold_res"}, result, exp);
      end
      start = 1'b0;
      @(negedge clk);
      chk({name, "_drop_rdy"}, {63'h0, ready}, 64'h0);
      chk({name, "_drop_res"}, result, 64'h0);
   endtask

   // Start a divide and cancel it after k iterations
   task automatic do_annul(input logic [31:0] a, input logic [31:0] b, input int k);
      @(negedge clk);
      start = 1'b1; annul = 1'b0; signed_div = 1'b0; opdata1 = a; opdata2 = b;
      repeat (k + 1) @(negedge clk);
      annul = 1'b1; start = 1'b0;
      @(negedge clk);
      annul = 1'b0;
      repeat (3) @(negedge clk);
      chk("annul_no_ready", {63'h0, ready}, 64'h0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
      opdata1 = 32'h0; opdata2 = 32'h0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      chk("reset_ready", {63'h0, ready}, 64'h0);
      chk("reset_result", result, 64'h0);
      rst = 1'b0;

      do_div(1'b0, 32'd7, 32'd2, {32'h1, 32'h3}, 33, 5, "divu_7_2");
      do_div(1'b1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 0, "div_m7_2");
      do_div(1'b1, 32'h7, 32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD}, 33, 1, "div_7_m2");
      do_div(1'b0, 32'hFFFFFFFF, 32'h0, 64'h0, 1, 2, "divu_by0");
      do_div(1'b0, 32'hFFFFFFFF, 32'h1, {32'h0, 32'hFFFFFFFF}, 33, 0, "divu_by1");
      do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33, 0, "div_min_m1");
      do_div(1'b1, 32'h0, 32'h0, 64'h0, 1, 0, "div_by0");

      do_annul(32'h1234, 32'h5, 10);
      do_div(1'b0, 32'h05050000, 32'h00010000, {32'h0, 32'h00000505}, 33, 0, "after_annul");
      do_annul(32'h99, 32'h0, 0);

      // Reset in the middle of an iteration run
      @(negedge clk);
      start = 1'b1; signed_div = 1'b0; opdata1 = 32'h1000; opdata2 = 32'h3;
      repeat (15) @(negedge clk);
      rst = 1'b1; start = 1'b0;
      @(negedge clk);
      chk("rst_on_ready", {63'h0, ready}, 64'h0);
      chk("rst_on_result", result, 64'h0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("rst_on_quiet", {63'h0, ready}, 64'h0);
      do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0, "divu_100_7");

      // Reset while a result is being held
      @(negedge clk);
      start = 1'b1; opdata1 = 32'd9; opdata2 = 32'd4;
      repeat (36) @(negedge clk);
      chk("end_before_rst", result, {32'd1, 32'd2});
      rst = 1'b1;
      @(negedge clk);
      chk("rst_end_ready", {63'h0, ready}, 64'h0);
      chk("rst_end_result", result, 64'h0);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);

      // Annul in END with start held, then annul+start in FREE must not accept
      @(negedge clk);
      start = 1'b1; opdata1 = 32'd50; opdata2 = 32'd5;
      repeat (36) @(negedge clk);
      chk("end_before_annul", result, {32'd0, 32'd10});
      annul = 1'b1;
      repeat (2) @(negedge clk);
      chk("annul_end_ready", {63'h0, ready}, 64'h0);
      chk("annul_end_result", result, 64'h0);
      annul = 1'b0; start = 1'b0;
      repeat (40) @(negedge clk);
      chk("annul_free_quiet", {63'h0, ready}, 64'h0);

      // Randomized divides with occasional cancellations
      for (int t = 0; t < 40; t++) begin
         logic        s;
         logic [31:0] a, b;
         int          sel;
         s   = 1'($urandom);
         a   = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0)      b = 32'h0;
         else if (sel == 1) b = 32'hFFFFFFFF;
         else if (sel == 2) b = 32'($urandom_range(1, 15));
         else               b = $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'h80000000;
         if ($urandom_range(0, 9) == 0) begin
            do_annul(a, b, $urandom_range(0, 31));
         end else begin
            do_div(s, a, b, ref_div(s, a, b), (b == 32'h0) ? 1 : 33,
                   $urandom_range(0, 3), "rand");
         end
      end

      repeat (2) @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
